// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet assembler.
// Byte1 bit positions follow the standard PS/2 stream packet layout.
package mouse_pkg;

  typedef enum logic [2:0] {
    SEND,
    WAIT_TX,
    WAIT_ACK,
    B1,
    B2,
    B3
  } state_e;

  localparam logic [7:0] PS2_CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] PS2_ACK           = 8'hFA;

  localparam int TMR_W = 24;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

endpackage

// File: rtl/mouse_packet_assembler_timeout_counter.sv
// Saturating idle counter with synchronous clear and a terminal-count flag.
// One instance serves both the ack wait and the inter-byte wait.
module timeout_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == i_tc_val);

endmodule

// File: rtl/mouse_packet_assembler.sv
// Enables PS/2 mouse streaming, then assembles 3-byte packets into signed
// 9-bit X/Y movement and button state, resynchronising on framing errors.
module mouse_packet_assembler
  import mouse_pkg::*;
#(
  parameter logic [7:0]       CMD_EN       = PS2_CMD_STREAM_EN,
  parameter logic [7:0]       ACK_BYTE     = PS2_ACK,
  parameter logic [TMR_W-1:0] ACK_TIMEOUT  = 24'd10_000_000,
  parameter logic [TMR_W-1:0] BYTE_TIMEOUT = 24'd2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic [7:0] tx_data,
  output logic       wr_ps2,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic       m_done_tick,
  output logic       init_done,
  output logic       frame_err
);

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_byte1;
  logic [7:0]       r_byte2;
  logic             r_wr_ps2;
  logic [8:0]       r_xm;
  logic [8:0]       r_ym;
  logic [2:0]       r_btnm;
  logic             r_m_done_tick;
  logic             r_init_done;
  logic             r_frame_err;
  logic             w_tmr_en;
  logic             w_tmr_clr;
  logic             w_tmr_tc;
  logic [TMR_W-1:0] w_tc_val;

  // Ack and inter-byte waits never overlap, so the limit just follows the state.
  assign w_tmr_en  = (r_state == WAIT_ACK) || (r_state == B2) || (r_state == B3);
  assign w_tmr_clr = rx_done_tick || (w_state_next != r_state);
  assign w_tc_val  = (r_state == WAIT_ACK) ? (ACK_TIMEOUT - TMR_W'(1))
                                           : (BYTE_TIMEOUT - TMR_W'(1));

  timeout_counter #(
    .W(TMR_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_tc_val(w_tc_val),
    .o_tc    (w_tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= SEND;
    else       r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for the next-state signal.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEND:     w_state_next = WAIT_TX;
      WAIT_TX:  if (tx_done_tick) w_state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (rx_done_tick) begin
          if (rx_data == ACK_BYTE) w_state_next = B1;
        end else if (w_tmr_tc) begin
          w_state_next = SEND;
        end
      end
      B1:       if (rx_done_tick && rx_data[SYNC]) w_state_next = B2;
      B2:       if (rx_done_tick) w_state_next = B3;
                else if (w_tmr_tc) w_state_next = B1;
      B3:       if (rx_done_tick || w_tmr_tc) w_state_next = B1;
      default:  w_state_next = SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte1       <= '0;
      r_byte2       <= '0;
      r_wr_ps2      <= 1'b0;
      r_xm          <= '0;
      r_ym          <= '0;
      r_btnm        <= '0;
      r_m_done_tick <= 1'b0;
      r_init_done   <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_wr_ps2      <= (r_state == SEND);
      r_m_done_tick <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        WAIT_ACK: if (rx_done_tick && (rx_data == ACK_BYTE)) r_init_done <= 1'b1;
        B1: begin
          if (rx_done_tick) begin
            if (rx_data[SYNC]) r_byte1     <= rx_data;
            else               r_frame_err <= 1'b1;
          end
        end
        B2: begin
          if (rx_done_tick)  r_byte2     <= rx_data;
          else if (w_tmr_tc) r_frame_err <= 1'b1;
        end
        B3: begin
          if (rx_done_tick) begin
            r_xm          <= r_byte1[XO] ? 9'd0 : {r_byte1[XS], r_byte2};
            r_ym          <= r_byte1[YO] ? 9'd0 : {r_byte1[YS], rx_data};
            r_btnm        <= {r_byte1[BTN_M], r_byte1[BTN_R], r_byte1[BTN_L]};
            r_m_done_tick <= 1'b1;
          end else if (w_tmr_tc) begin
            r_frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data     = CMD_EN;
  assign wr_ps2      = r_wr_ps2;
  assign xm          = r_xm;
  assign ym          = r_ym;
  assign btnm        = r_btnm;
  assign m_done_tick = r_m_done_tick;
  assign init_done   = r_init_done;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// Directed self-checking bench for mouse_packet_assembler with shortened
// ack (100) and inter-byte (50) timeouts.
module tb_mouse_packet_assembler;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic [7:0] tx_data;
  logic       wr_ps2;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  logic       init_done;
  logic       frame_err;

  int n_pass  = 0;
  int n_total = 0;

  mouse_packet_assembler #(
    .ACK_TIMEOUT (24'd100),
    .BYTE_TIMEOUT(24'd50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick),
    .tx_data     (tx_data),
    .wr_ps2      (wr_ps2),
    .xm          (xm),
    .ym          (ym),
    .btnm        (btnm),
    .m_done_tick (m_done_tick),
    .init_done   (init_done),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered outputs reflecting the byte are visible when this returns.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1;
    tx_done_tick = 1'b1;
    @(posedge clk); #1;
    tx_done_tick = 1'b0;
  endtask

  task automatic wait_wr(input int budget, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (wr_ps2 === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    int cyc;
    reset = 1'b1; rx_data = 8'h00; rx_done_tick = 1'b0; tx_done_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({wr_ps2, m_done_tick, init_done, frame_err} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {wr_ps2, m_done_tick, init_done, frame_err});
    else n_pass++;
    n_total++;
    if ({xm, ym, btnm} !== 21'd0)
      $display("FAIL reset_data got xm=%h ym=%h btnm=%b exp=0", xm, ym, btnm);
    else n_pass++;
    n_total++;
    if (tx_data !== 8'hF4) $display("FAIL reset_tx_data got=%h exp=f4", tx_data);
    else n_pass++;
    reset = 1'b0;
    wait_wr(5, seen, cyc);
    n_total++;
    if (!seen) $display("FAIL first_wr_ps2 got=none exp=pulse");
    else n_pass++;
    n_total++;
    if (tx_data !== 8'hF4) $display("FAIL first_cmd got=%h exp=f4", tx_data);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (wr_ps2 !== 1'b0) $display("FAIL wr_ps2_width got=%b exp=0", wr_ps2);
    else n_pass++;
  endtask

  task automatic test_ack_timeout();
    bit seen;
    int cyc;
    pulse_tx_done();
    send_byte(8'hFE);
    n_total++;
    if (init_done !== 1'b0) $display("FAIL nack_init got=%b exp=0", init_done);
    else n_pass++;
    wait_wr(130, seen, cyc);
    n_total++;
    if (!seen || cyc < 90 || cyc > 110)
      $display("FAIL ack_timeout_resend got seen=%0d cycles=%0d exp seen=1 cycles~101", seen, cyc);
    else n_pass++;
    n_total++;
    if (tx_data !== 8'hF4 || init_done !== 1'b0)
      $display("FAIL resend_cmd got tx=%h init=%b exp tx=f4 init=0", tx_data, init_done);
    else n_pass++;
  endtask

  task automatic test_init();
    pulse_tx_done();
    send_byte(8'hFA);
    n_total++;
    if (init_done !== 1'b1) $display("FAIL ack_init got=%b exp=1", init_done);
    else n_pass++;
  endtask

  task automatic test_packet();
    send_byte(8'h19);
    send_byte(8'h05);
    n_total++;
    if (m_done_tick !== 1'b0) $display("FAIL early_tick got=%b exp=0", m_done_tick);
    else n_pass++;
    send_byte(8'hFB);
    n_total++;
    if (m_done_tick !== 1'b1) $display("FAIL pkt1_tick got=%b exp=1", m_done_tick);
    else n_pass++;
    n_total++;
    if (xm !== 9'h105 || ym !== 9'h0FB || btnm !== 3'b001)
      $display("FAIL pkt1_data got xm=%h ym=%h btnm=%b exp xm=105 ym=0fb btnm=001", xm, ym, btnm);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (m_done_tick !== 1'b0 || xm !== 9'h105)
      $display("FAIL pkt1_hold got tick=%b xm=%h exp tick=0 xm=105", m_done_tick, xm);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    send_byte(8'h00);
    n_total++;
    if (frame_err !== 1'b1) $display("FAIL sync_frame_err got=%b exp=1", frame_err);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (frame_err !== 1'b0) $display("FAIL frame_err_width got=%b exp=0", frame_err);
    else n_pass++;
    send_byte(8'h08);
    send_byte(8'h03);
    send_byte(8'h02);
    n_total++;
    if (m_done_tick !== 1'b1 || xm !== 9'h003 || ym !== 9'h002 || btnm !== 3'b000)
      $display("FAIL resync_pkt got tick=%b xm=%h ym=%h btnm=%b exp tick=1 xm=003 ym=002 btnm=000",
               m_done_tick, xm, ym, btnm);
    else n_pass++;
  endtask

  task automatic test_byte_timeout();
    bit seen_err  = 1'b0;
    bit seen_tick = 1'b0;
    int cyc = 0;
    send_byte(8'h08);
    send_byte(8'h10);
    while (!seen_err && cyc < 70) begin
      @(posedge clk); #1;
      cyc++;
      if (m_done_tick === 1'b1) seen_tick = 1'b1;
      if (frame_err === 1'b1) seen_err = 1'b1;
    end
    n_total++;
    if (!seen_err || cyc < 45 || cyc > 55)
      $display("FAIL byte_timeout got seen=%0d cycles=%0d exp seen=1 cycles~50", seen_err, cyc);
    else n_pass++;
    n_total++;
    if (seen_tick) $display("FAIL timeout_no_tick got=1 exp=0");
    else n_pass++;
    send_byte(8'h0A);
    send_byte(8'h01);
    send_byte(8'h01);
    n_total++;
    if (m_done_tick !== 1'b1 || xm !== 9'h001 || ym !== 9'h001 || btnm !== 3'b010)
      $display("FAIL post_timeout_pkt got tick=%b xm=%h ym=%h btnm=%b exp tick=1 xm=001 ym=001 btnm=010",
               m_done_tick, xm, ym, btnm);
    else n_pass++;
  endtask

  task automatic test_overflow();
    send_byte(8'h48);
    send_byte(8'h7F);
    send_byte(8'h04);
    n_total++;
    if (m_done_tick !== 1'b1 || xm !== 9'h000 || ym !== 9'h004 || btnm !== 3'b000)
      $display("FAIL x_overflow got tick=%b xm=%h ym=%h btnm=%b exp tick=1 xm=000 ym=004 btnm=000",
               m_done_tick, xm, ym, btnm);
    else n_pass++;
    send_byte(8'hBF);
    send_byte(8'h11);
    send_byte(8'h22);
    n_total++;
    if (m_done_tick !== 1'b1 || xm !== 9'h111 || ym !== 9'h000 || btnm !== 3'b111)
      $display("FAIL y_overflow got tick=%b xm=%h ym=%h btnm=%b exp tick=1 xm=111 ym=000 btnm=111",
               m_done_tick, xm, ym, btnm);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    bit seen_wr   = 1'b0;
    bit seen_tick = 1'b0;
    int cyc = 0;
    send_byte(8'h09);
    send_byte(8'h22);
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (m_done_tick !== 1'b0 || init_done !== 1'b0 || xm !== 9'd0)
      $display("FAIL mid_reset got tick=%b init=%b xm=%h exp tick=0 init=0 xm=000",
               m_done_tick, init_done, xm);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    while (!seen_wr && cyc < 5) begin
      @(posedge clk); #1;
      cyc++;
      if (m_done_tick === 1'b1) seen_tick = 1'b1;
      if (wr_ps2 === 1'b1) seen_wr = 1'b1;
    end
    n_total++;
    if (!seen_wr || seen_tick)
      $display("FAIL reset_resend got wr=%0d tick=%0d exp wr=1 tick=0", seen_wr, seen_tick);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ack_timeout();
    test_init();
    test_packet();
    test_frame_err();
    test_byte_timeout();
    test_overflow();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
